// File: rtl/reg_bank_mover.sv
// Register-bank mover: single WRITE/READ, block COPY and block FILL
// over an external bank with a combinational read port and a clocked write port.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   cmd_*           command channel (valid/ready), accepted only in IDLE
//   rsp_*           response channel (valid/ready), held until consumed
//   wr_en/w_*       bank write port, registered by the bank on posedge clk
//   rd1_en/r_*      bank read port, r_data1 combinational from r_addr1
//   busy            high whenever the FSM is not in IDLE
module reg_bank_mover #(
  parameter int WL = 32,
  parameter int AL = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AL-1:0] cmd_addr,
  input  logic [AL-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  input  logic [WL-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_op,
  output logic [WL-1:0] rsp_data,
  output logic          wr_en,
  output logic [AL-1:0] w_addr,
  output logic [WL-1:0] w_data,
  output logic          rd1_en,
  output logic [AL-1:0] r_addr1,
  input  logic [WL-1:0] r_data1,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_MOVE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AL-1:0] src_q, src_d;
  logic [AL-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [WL-1:0] dat_q, dat_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [WL-1:0] rdat_q, rdat_d;

  logic [LW-1:0] idx_nxt;
  logic [AL-1:0] idx_ext;

  assign idx_nxt = idx_q + LW'(1);
  assign idx_ext = AL'(idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      dat_q   <= '0;
      idx_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      rdat_q  <= rdat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    dat_d     = dat_q;
    idx_d     = idx_q;
    rdat_d    = rdat_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_op    = '0;
    rsp_data  = '0;
    wr_en     = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    rd1_en    = 1'b0;
    r_addr1   = '0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          src_d  = cmd_addr;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          dat_d  = cmd_data;
          idx_d  = '0;
          rdat_d = '0;
          unique case (cmd_op)
            OP_WRITE: state_d = S_WRITE;
            OP_READ:  state_d = S_READ;
            default:  state_d = (cmd_len == '0) ? S_RESP : S_MOVE;
          endcase
        end
      end

      S_WRITE: begin
        wr_en   = 1'b1;
        w_addr  = src_q;
        w_data  = dat_q;
        state_d = S_RESP;
      end

      S_READ: begin
        rd1_en  = 1'b1;
        r_addr1 = src_q;
        rdat_d  = r_data1;
        state_d = S_RESP;
      end

      S_MOVE: begin
        // Bank write lands at the end of this cycle, so the next
        // read of an overlapping COPY already sees it.
        wr_en  = 1'b1;
        w_addr = dst_q + idx_ext;
        if (op_q == OP_COPY) begin
          rd1_en  = 1'b1;
          r_addr1 = src_q + idx_ext;
          w_data  = r_data1;
        end else begin
          w_data = dat_q;
        end
        if (idx_nxt == len_q) begin
          state_d = S_RESP;
        end else begin
          idx_d = idx_nxt;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_op    = op_q;
        rsp_data  = rdat_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_bank_mover.sv
// Directed bench for reg_bank_mover with a small bank model,
// a response scoreboard and a write log.
module tb_reg_bank_mover;

  localparam int WL = 32;
  localparam int AL = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AL-1:0] cmd_addr;
  logic [AL-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [WL-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_op;
  logic [WL-1:0] rsp_data;
  logic          wr_en;
  logic [AL-1:0] w_addr;
  logic [WL-1:0] w_data;
  logic          rd1_en;
  logic [AL-1:0] r_addr1;
  logic [WL-1:0] r_data1;
  logic          busy;

  always #5 clk = ~clk;

  reg_bank_mover #(.WL(WL), .AL(AL), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_data(rsp_data),
    .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .rd1_en(rd1_en), .r_addr1(r_addr1), .r_data1(r_data1),
    .busy(busy)
  );

  logic [WL-1:0] mem [2**AL];
  logic          bank_clr;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 2**AL; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data1 = mem[r_addr1];

  typedef struct packed {
    logic [1:0]    op;
    logic [WL-1:0] data;
  } rsp_t;

  rsp_t          sb [$];
  logic [AL-1:0] wl_a [$];
  logic [WL-1:0] wl_d [$];
  logic [AL-1:0] ea [$];
  logic [WL-1:0] ed [$];
  int            rd_n;
  int            cyc;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_cycle();
    if (wr_en === 1'b1) begin
      wl_a.push_back(w_addr);
      wl_d.push_back(w_data);
    end
    if (rd1_en === 1'b1) rd_n++;
  endtask

  task automatic issue(input logic [1:0] op, input logic [AL-1:0] a,
                       input logic [AL-1:0] d, input logic [LW-1:0] l,
                       input logic [WL-1:0] dat, input logic [WL-1:0] exp_rd);
    rsp_t e;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_dst   = d;
    cmd_len   = l;
    cmd_data  = dat;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    e.op   = op;
    e.data = (op == 2'b01) ? exp_rd : '0;
    sb.push_back(e);
    wl_a.delete();
    wl_d.delete();
    ea.delete();
    ed.delete();
    rd_n = 0;
    cyc  = 1;
  endtask

  task automatic run_to_rsp(input int exp_lat);
    while (rsp_valid !== 1'b1 && cyc < 300) begin
      log_cycle();
      step();
      cyc++;
    end
    chk("rsp_latency", cyc, exp_lat);
    chk("rsp_valid", rsp_valid, 1);
  endtask

  task automatic consume(input int hold);
    rsp_t e;
    e = sb.pop_front();
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_op", rsp_op, e.op);
      chk("hold_data", rsp_data, e.data);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_busy", busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    chk("rsp_op", rsp_op, e.op);
    chk("rsp_data", rsp_data, e.data);
    chk("cmd_ready_on_consume", cmd_ready, 0);
    step();
    rsp_ready = 1'b0;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  task automatic chk_wlog(input string tag);
    chk({tag, "_nwr"}, wl_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wl_a.size(); i++) begin
      chk({tag, "_waddr"}, wl_a[i], ea[i]);
      chk({tag, "_wdata"}, wl_d[i], ed[i]);
    end
  endtask

  task automatic do_write(input logic [AL-1:0] a, input logic [WL-1:0] d);
    issue(2'b00, a, '0, '0, d, '0);
    run_to_rsp(2);
    consume(0);
  endtask

  task automatic do_read(input logic [AL-1:0] a, input logic [WL-1:0] exp);
    issue(2'b01, a, '0, '0, '0, exp);
    run_to_rsp(2);
    chk("read_rd_n", rd_n, 1);
    consume(0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_outs"},
        {rsp_valid, rsp_op, rsp_data, wr_en, rd1_en, busy},
        '0);
    chk({tag, "_addrs"}, {w_addr, w_data, r_addr1}, '0);
  endtask

  initial begin
    int nv;
    rst       = 1'b1;
    bank_clr  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk_idle_zero("reset");
    rst      = 1'b0;
    bank_clr = 1'b0;
    step();

    // WRITE addr 5
    issue(2'b00, 8'd5, '0, '0, 32'hDEADBEEF, '0);
    chk("wr_T1_en", wr_en, 1);
    chk("wr_T1_addr", w_addr, 5);
    chk("wr_T1_data", w_data, 32'hDEADBEEF);
    chk("wr_T1_busy", busy, 1);
    chk("wr_T1_ready", cmd_ready, 0);
    run_to_rsp(2);
    ea.push_back(8'd5);
    ed.push_back(32'hDEADBEEF);
    chk_wlog("write");
    consume(0);

    // READ addr 5
    issue(2'b01, 8'd5, '0, '0, '0, 32'hDEADBEEF);
    chk("rd_T1_en", rd1_en, 1);
    chk("rd_T1_addr", r_addr1, 5);
    chk("rd_T1_wr", wr_en, 0);
    run_to_rsp(2);
    chk("read_nwr", wl_a.size(), 0);
    consume(0);

    // FILL wrapping past the top of the address space
    issue(2'b11, '0, 8'd254, 8'd4, 32'hA5A5A5A5, '0);
    run_to_rsp(5);
    for (int i = 0; i < 4; i++) begin
      ea.push_back(8'(254 + i));
      ed.push_back(32'hA5A5A5A5);
    end
    chk_wlog("fill_wrap");
    chk("fill_rd_n", rd_n, 0);
    consume(0);
    do_read(8'd1, 32'hA5A5A5A5);
    do_read(8'd253, 32'h0);

    // overlapping COPY replicates the source word
    for (int i = 0; i < 4; i++) do_write(8'(10 + i), 32'(i + 1));
    issue(2'b10, 8'd10, 8'd11, 8'd3, '0, '0);
    run_to_rsp(4);
    for (int i = 0; i < 3; i++) begin
      ea.push_back(8'(11 + i));
      ed.push_back(32'd1);
    end
    chk_wlog("copy_ovl");
    chk("copy_rd_n", rd_n, 3);
    consume(0);
    for (int i = 0; i < 4; i++) do_read(8'(10 + i), 32'd1);

    // COPY len 0: no bank access
    issue(2'b10, 8'd10, 8'd20, 8'd0, '0, '0);
    chk("copy0_wr", wr_en, 0);
    chk("copy0_rd", rd1_en, 0);
    run_to_rsp(1);
    chk("copy0_nwr", wl_a.size(), 0);
    chk("copy0_rd_n", rd_n, 0);
    consume(0);

    // response backpressure on a READ
    issue(2'b01, 8'd5, '0, '0, '0, 32'hDEADBEEF);
    run_to_rsp(2);
    consume(5);

    // reset in the middle of a FILL
    issue(2'b11, '0, 8'd50, 8'd8, 32'h12345678, '0);
    log_cycle();
    step();
    log_cycle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("abort");
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      log_cycle();
      if (rsp_valid === 1'b1) nv++;
      step();
    end
    chk("abort_no_rsp", nv, 0);
    void'(sb.pop_back());
    ea.push_back(8'd50);
    ed.push_back(32'h12345678);
    ea.push_back(8'd51);
    ed.push_back(32'h12345678);
    chk_wlog("abort");
    do_read(8'd51, 32'h12345678);
    do_read(8'd52, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_mover.md
REG_BANK_MOVER -- requirements
Module: reg_bank_mover

Interface
REQ-001 The block SHALL have parameter WL, default 32, register word length in bits.
REQ-002 The block SHALL have parameter AL, default 32, register-bank address width in bits.
REQ-003 The block SHALL have parameter LW, default 8, block-length field width in bits.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port cmd_valid  input  1  command offered.
REQ-007 The block SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 The block SHALL have port cmd_op  input  2  00 WRITE, 01 READ, 10 COPY, 11 FILL.
REQ-009 The block SHALL have port cmd_addr  input  AL  single-access address, or COPY source base.
REQ-010 The block SHALL have port cmd_dst  input  AL  COPY/FILL destination base.
REQ-011 The block SHALL have port cmd_len  input  LW  COPY/FILL word count.
REQ-012 The block SHALL have port cmd_data  input  WL  WRITE data, or FILL pattern.
REQ-013 The block SHALL have port rsp_valid  output  1  response available.
REQ-014 The block SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-015 The block SHALL have port rsp_op  output  2  echo of the completed command's cmd_op.
REQ-016 The block SHALL have port rsp_data  output  WL  READ result; zero for all other ops.
REQ-017 The block SHALL have bank-side ports wr_en out 1, w_addr out AL, w_data out WL, rd1_en out 1, r_addr1 out AL, and r_data1 in WL; the bank read is combinational and the bank write is registered on posedge clk.
REQ-018 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WRITE, READ, MOVE and RESP.
REQ-020 cmd_ready SHALL be high only in IDLE; the acceptance cycle T is the cycle in which cmd_valid and cmd_ready are both high, and all cmd_* fields SHALL be registered at T.
REQ-021 WRITE: in cycle T+1, wr_en=1, w_addr=cmd_addr and w_data=cmd_data; RESP SHALL be entered at T+2.
REQ-022 READ: in cycle T+1, rd1_en=1 and r_addr1=cmd_addr; r_data1 SHALL be captured into rsp_data at the end of T+1; RESP SHALL be entered at T+2.
REQ-023 COPY with len N>0 SHALL, in cycles T+1..T+N and at index i=0..N-1, drive rd1_en=1, r_addr1=src+i, wr_en=1, w_addr=dst+i and w_data=r_data1, giving one word per cycle in ascending order; RESP SHALL be entered at T+N+1.
REQ-024 FILL with len N>0 SHALL, in cycles T+1..T+N, drive wr_en=1, w_addr=dst+i and w_data=cmd_data, with rd1_en=0; RESP SHALL be entered at T+N+1.
REQ-025 For COPY or FILL with len=0, the block SHALL perform no bank access and SHALL enter RESP at T+1.
REQ-026 All address arithmetic SHALL be modulo 2**AL; an address incremented past 2**AL-1 SHALL wrap to 0.
REQ-027 For overlapping COPY, each read SHALL observe all bank writes made in earlier cycles; with dst=src+1, the word at src is therefore replicated (defined behaviour, not an error).
REQ-028 In RESP, rsp_valid=1, and rsp_op and rsp_data SHALL be held stable until rsp_ready=1, after which the FSM SHALL return to IDLE in the next cycle.
REQ-029 A new command SHALL NOT be accepted in the cycle in which a response is consumed; the earliest next acceptance is in IDLE, one cycle later.
REQ-030 Outside the active cycles defined above, wr_en and rd1_en SHALL be 0, and w_addr, w_data and r_addr1 SHALL be 0.
REQ-031 The internal word counter SHALL be LW bits wide; the maximum length is 2**LW-1.

Reset
REQ-032 On rst=1 at a posedge, the FSM SHALL go to IDLE, and cmd_ready SHALL read 1 in the following cycle.
REQ-033 On that reset, rsp_valid, rsp_op, rsp_data, wr_en, rd1_en, w_addr, w_data, r_addr1 and busy SHALL all be 0.
REQ-034 rst SHALL take priority over all other inputs; a reset during MOVE SHALL abort the operation, with no further bank writes from the cycle after reset and no response generated.

Verification
REQ-035 Bench SHALL cover: WRITE addr=5, data=0xDEADBEEF, then READ addr=5 -> wr_en pulse at T+1, and the read response has rsp_op=01 and rsp_data=0xDEADBEEF at T+2.
REQ-036 Bench SHALL cover: FILL dst=2**AL-2, len=4, data=0xA5A5A5A5 -> writes to addresses 2**AL-2, 2**AL-1, 0, 1, and rsp_valid at T+5.
REQ-037 Bench SHALL cover: preload words 10..13 = 1,2,3,4, then COPY src=10, dst=11, len=3 -> words 11..13 all equal 1, with rsp_op=10.
REQ-038 Bench SHALL cover: COPY len=0 -> no wr_en or rd1_en asserted, and rsp_valid at T+1.
REQ-039 Bench SHALL cover: rsp_ready held low for 5 cycles -> rsp_valid, rsp_op and rsp_data stable, cmd_ready=0, and busy=1 throughout.
REQ-040 Bench SHALL cover: FILL len=8 with rst asserted at T+3 -> exactly 2 writes (dst, dst+1), all outputs 0 in the next cycle, and no response.
